act_mac_accum: RTL and testbench

- Downstream stage of the input activation controller.
- Consumes the signed 8-bit activation stream (data + valid) together with a weight byte that is aligned to the same valid.
- Performs a signed multiply-accumulate over a configured number of elements, adds bias, applies optional ReLU, then requantizes (arithmetic shift + saturate) to one 8-bit output activation.
- One dot product per START; the result is presented with a one-cycle valid pulse.

---
 rtl/act_mac_accum.sv | 132 +++++++++++++
 tb/tb_act_mac_accum.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_mac_accum.sv
// Signed 8-bit dot-product engine: multiply-accumulate over NUM_ELEMS activation/weight
// pairs, add bias, optional ReLU, then requantize (arithmetic shift + saturate) to 8 bits.
module act_mac_accum #(
  parameter int ACT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        START,
  input  logic        [CNT_WIDTH-1:0] NUM_ELEMS,
  input  logic signed [ACC_WIDTH-1:0] BIAS,
  input  logic        [4:0]           Q_SHIFT,
  input  logic                        RELU_EN,
  input  logic signed [ACT_WIDTH-1:0] IN_ACT_DATA,
  input  logic                        IN_ACT_VALID,
  input  logic signed [ACT_WIDTH-1:0] WEIGHT_DATA,
  output logic signed [ACT_WIDTH-1:0] OUT_DATA,
  output logic                        OUT_VALID,
  output logic signed [ACC_WIDTH-1:0] ACC_OUT,
  output logic                        BUSY
);

  localparam int PROD_W = 2 * ACT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (ACT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_RESULT} state_t;

  state_t                      r_state, w_next;
  logic        [CNT_WIDTH-1:0] r_num, r_cnt;
  logic signed [ACC_WIDTH-1:0] r_bias;
  logic        [4:0]           r_shift;
  logic                        r_relu;
  logic signed [PROD_W-1:0]    r_prod_p1;
  logic                        r_vld_p1;
  logic signed [ACC_WIDTH-1:0] r_acc_p2;
  logic signed [ACT_WIDTH-1:0] r_out_data;
  logic signed [ACC_WIDTH-1:0] r_acc_out;
  logic                        r_out_vld;

  logic                        w_start, w_take, w_last;
  logic signed [PROD_W-1:0]    w_prod_p0;
  logic signed [ACC_WIDTH-1:0] w_prod_ext, w_sum;

  // ReLU, floor shift, then clamp to the signed output range.
  function automatic logic signed [ACT_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] s,
    input logic        [4:0]           sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH-1:0] v;
    logic signed [ACC_WIDTH-1:0] r;
    v = (relu && (s < 0)) ? '0 : s;
    r = v >>> sh;
    if (r > SAT_MAX)      requant = ACT_WIDTH'(SAT_MAX);
    else if (r < SAT_MIN) requant = ACT_WIDTH'(SAT_MIN);
    else                  requant = ACT_WIDTH'(r);
  endfunction

  assign w_start    = (r_state == S_IDLE) && START;
  assign w_take     = (r_state == S_ACCUM) && IN_ACT_VALID;
  assign w_last     = w_take && (r_cnt == (r_num - CNT_WIDTH'(1)));
  assign w_prod_p0  = $signed({{ACT_WIDTH{IN_ACT_DATA[ACT_WIDTH-1]}}, IN_ACT_DATA}) *
                      $signed({{ACT_WIDTH{WEIGHT_DATA[ACT_WIDTH-1]}}, WEIGHT_DATA});
  assign w_prod_ext = $signed({{(ACC_WIDTH-PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1});
  assign w_sum      = r_acc_p2 + r_bias;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (START) w_next = (NUM_ELEMS == '0) ? S_DRAIN : S_ACCUM;
      S_ACCUM:  if (w_last) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_RESULT;
      S_RESULT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_num      <= '0;
      r_cnt      <= '0;
      r_bias     <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_prod_p1  <= '0;
      r_vld_p1   <= 1'b0;
      r_acc_p2   <= '0;
      r_out_data <= '0;
      r_acc_out  <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= (r_state == S_RESULT);
      if (w_start) begin
        r_num     <= NUM_ELEMS;
        r_bias    <= BIAS;
        r_shift   <= Q_SHIFT;
        r_relu    <= RELU_EN;
        r_cnt     <= '0;
        r_acc_p2  <= '0;
        r_prod_p1 <= '0;
        r_vld_p1  <= 1'b0;
      end else begin
        // p0 -> p1: register the product of an accepted pair.
        r_vld_p1 <= w_take;
        if (w_take) begin
          r_prod_p1 <= w_prod_p0;
          r_cnt     <= r_cnt + CNT_WIDTH'(1);
        end
        // p1 -> p2: fold the registered product into the wrapping accumulator.
        if (r_vld_p1) r_acc_p2 <= r_acc_p2 + w_prod_ext;
      end
      // p2 -> out: bias, requantize and present the result.
      if (r_state == S_RESULT) begin
        r_acc_out  <= w_sum;
        r_out_data <= requant(w_sum, r_shift, r_relu);
      end
    end
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_vld;
  assign ACC_OUT   = r_acc_out;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_act_mac_accum.sv
// Randomized and directed bench for act_mac_accum against a plain-arithmetic dot-product model.
module tb_act_mac_accum;

  logic               CLK = 1'b0;
  logic               RESETN;
  logic               START;
  logic        [15:0] NUM_ELEMS;
  logic signed [31:0] BIAS;
  logic        [4:0]  Q_SHIFT;
  logic               RELU_EN;
  logic signed [7:0]  IN_ACT_DATA;
  logic               IN_ACT_VALID;
  logic signed [7:0]  WEIGHT_DATA;
  logic signed [7:0]  OUT_DATA;
  logic               OUT_VALID;
  logic signed [31:0] ACC_OUT;
  logic               BUSY;

  act_mac_accum dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .NUM_ELEMS(NUM_ELEMS), .BIAS(BIAS),
    .Q_SHIFT(Q_SHIFT), .RELU_EN(RELU_EN), .IN_ACT_DATA(IN_ACT_DATA),
    .IN_ACT_VALID(IN_ACT_VALID), .WEIGHT_DATA(WEIGHT_DATA), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .ACC_OUT(ACC_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  int q_act[$];
  int q_wt[$];
  bit q_vld[$];

  int     pulses;
  int     n_edges;
  int     lat;
  bit     e_armed;
  longint cap_data;
  longint cap_acc;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_requant(input longint s, input int sh, input bit relu);
    longint v, d;
    v = s;
    if (relu && v < 0) v = 0;
    d = longint'(1) << sh;
    if (v >= 0) v = v / d;
    else        v = -((-v + d - 1) / d);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // One clock edge; outputs observed 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
    if (e_armed) n_edges++;
    if (OUT_VALID) begin
      pulses++;
      lat      = n_edges;
      cap_data = longint'(OUT_DATA);
      cap_acc  = longint'(ACC_OUT);
    end
  endtask

  task automatic push(input bit v, input int a, input int w);
    q_vld.push_back(v);
    q_act.push_back(a);
    q_wt.push_back(w);
  endtask

  task automatic clear_q();
    q_vld.delete();
    q_act.delete();
    q_wt.delete();
  endtask

  task automatic run(input int n, input int bias, input int sh, input bit relu,
                     input bit busy_start, input string tag);
    longint sum;
    int taken;
    logic signed [31:0] s32;
    longint exp_acc, exp_data;
    sum = 0;
    taken = 0;
    foreach (q_vld[i]) begin
      if (q_vld[i] && taken < n) begin
        sum += longint'(q_act[i]) * longint'(q_wt[i]);
        taken++;
      end
    end
    s32      = 32'(sum + longint'(bias));
    exp_acc  = longint'(s32);
    exp_data = ref_requant(exp_acc, sh, relu);

    pulses = 0; n_edges = 0; lat = -1; e_armed = 0;
    START = 1'b1; NUM_ELEMS = 16'(n); BIAS = bias; Q_SHIFT = 5'(sh); RELU_EN = relu;
    IN_ACT_VALID = 1'b0;
    if (n == 0) e_armed = 1;
    step();
    START = 1'b0;
    NUM_ELEMS = 16'($urandom_range(1, 9)); BIAS = $urandom; Q_SHIFT = 5'($urandom); RELU_EN = ~relu;
    if (busy_start) begin
      START = 1'b1;
      chk({tag, "_busy"}, longint'(BUSY), 1);
      step();
      step();
      START = 1'b0;
    end
    taken = 0;
    foreach (q_vld[i]) begin
      IN_ACT_VALID = q_vld[i];
      IN_ACT_DATA  = 8'(q_act[i]);
      WEIGHT_DATA  = 8'(q_wt[i]);
      if (q_vld[i]) begin
        taken++;
        if (taken == n) begin
          e_armed = 1;
          n_edges = 0;
        end
      end
      step();
    end
    IN_ACT_VALID = 1'b0;
    IN_ACT_DATA  = 8'($urandom);
    WEIGHT_DATA  = 8'($urandom);
    for (int k = 0; k < 20 && pulses == 0; k++) step();
    chk({tag, "_got_pulse"}, longint'(pulses), 1);
    chk({tag, "_latency"}, longint'(lat), 3);
    chk({tag, "_acc"}, cap_acc, exp_acc);
    chk({tag, "_data"}, cap_data, exp_data);
    step();
    chk({tag, "_single_pulse"}, longint'(pulses), 1);
    chk({tag, "_idle_after"}, longint'(BUSY), 0);
    e_armed = 0;
  endtask

  initial begin
    RESETN = 1'b0; START = 1'b0; NUM_ELEMS = '0; BIAS = '0; Q_SHIFT = '0; RELU_EN = 1'b0;
    IN_ACT_DATA = '0; IN_ACT_VALID = 1'b0; WEIGHT_DATA = '0;
    e_armed = 0; pulses = 0; n_edges = 0; lat = -1; cap_data = 0; cap_acc = 0;
    #12;
    chk("rst_out_data", longint'(OUT_DATA), 0);
    chk("rst_acc_out", longint'(ACC_OUT), 0);
    chk("rst_out_valid", longint'(OUT_VALID), 0);
    chk("rst_busy", longint'(BUSY), 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    step();

    clear_q();
    for (int i = 1; i <= 4; i++) push(1, i, 2);
    run(4, 5, 1, 0, 0, "b2b");

    clear_q();
    push(1, 1, 2); push(0, 55, 9); push(0, -7, 3); push(1, 2, 2);
    push(0, 100, 100); push(1, 3, 2); push(1, 4, 2);
    push(1, 77, 66); push(1, -99, 11);
    run(4, 5, 1, 0, 0, "gaps");

    clear_q();
    push(1, -10, 3); push(1, -20, 3);
    run(2, 0, 0, 1, 0, "relu");
    run(2, 0, 2, 0, 0, "floor");

    clear_q();
    for (int i = 0; i < 4; i++) push(1, 127, 127);
    run(4, 0, 0, 0, 0, "sat_hi");
    clear_q();
    for (int i = 0; i < 4; i++) push(1, -128, 127);
    run(4, -1, 0, 0, 0, "sat_lo");

    clear_q();
    run(0, -300, 0, 0, 1, "zero_elems");

    // Abort a run midway with reset; nothing may come out of it.
    clear_q();
    pulses = 0;
    START = 1'b1; NUM_ELEMS = 16'd4; BIAS = 0; Q_SHIFT = 0; RELU_EN = 0;
    step();
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_ACT_VALID = 1'b1; IN_ACT_DATA = 8'sd9; WEIGHT_DATA = 8'sd9;
      step();
    end
    #2 RESETN = 1'b0;
    #1;
    chk("abort_busy", longint'(BUSY), 0);
    chk("abort_acc_out", longint'(ACC_OUT), 0);
    IN_ACT_VALID = 1'b0;
    step();
    step();
    RESETN = 1'b1;
    step();
    step();
    chk("abort_no_pulse", longint'(pulses), 0);
    push(1, 5, 5);
    run(1, 0, 0, 0, 0, "after_abort");

    for (int t = 0; t < 12; t++) begin
      int n, bias, sh;
      bit relu;
      string tag;
      clear_q();
      n = $urandom_range(0, 6);
      for (int got = 0; got < n; ) begin
        bit v;
        v = ($urandom_range(0, 9) < 7);
        push(v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        if (v) got++;
      end
      for (int x = 0; x < int'($urandom_range(0, 2)); x++)
        push(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      bias = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 20000)) - 10000;
      sh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
      relu = 1'($urandom_range(0, 1));
      tag  = $sformatf("rnd%0d", t);
      run(n, bias, sh, relu, 1'($urandom_range(0, 1)), tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
